// File: rtl/sbox_trace_scheduler.sv
// Sequencer for the LFSR -> 4x S-box -> text_reg datapath: quiet period, LFSR advance,
// load round, chained S-box rounds, with scope trigger and start/busy/done handshake.
module sbox_trace_scheduler #(
  parameter int QUIET_W  = 8,
  parameter int ROUNDS_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                ICE_CLK,
  input  logic                resetn,
  input  logic                start,
  input  logic                free_run,
  input  logic                abort,
  input  logic [QUIET_W-1:0]  cfg_quiet,
  input  logic [ROUNDS_W-1:0] cfg_rounds,
  output logic                lfsr_shift_en,
  output logic                text_in_sel,
  output logic                text_reg_en,
  output logic                trigger,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    trace_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIET,
    S_ADVANCE,
    S_LOAD,
    S_CHAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [QUIET_W-1:0]  quiet_cnt_q, quiet_cnt_d;
  logic [ROUNDS_W-1:0] round_cnt_q, round_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                arm;
  logic [ROUNDS_W-1:0] rounds_eff;

  always_comb begin
    rounds_eff = (cfg_rounds == '0) ? ROUNDS_W'(1) : cfg_rounds;
  end

  always_comb begin
    state_d     = state_q;
    quiet_cnt_d = quiet_cnt_q;
    round_cnt_d = round_cnt_q;
    count_d     = count_q;
    arm         = 1'b0;

    unique case (state_q)
      S_IDLE:    arm = (start | free_run) & ~abort;
      S_QUIET: begin
        if (quiet_cnt_q == QUIET_W'(1)) state_d = S_ADVANCE;
        else                            quiet_cnt_d = quiet_cnt_q - QUIET_W'(1);
      end
      S_ADVANCE: state_d = S_LOAD;
      // round_cnt counts the text_reg_en cycles still owed, including the current one
      S_LOAD, S_CHAIN: begin
        if (round_cnt_q == ROUNDS_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_CHAIN;
          round_cnt_d = round_cnt_q - ROUNDS_W'(1);
        end
      end
      S_DONE: begin
        count_d = count_q + CNT_W'(1);
        if (free_run) arm = 1'b1;
        else          state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase

    if (arm) begin
      quiet_cnt_d = cfg_quiet;
      round_cnt_d = rounds_eff;
      state_d     = (cfg_quiet == '0) ? S_ADVANCE : S_QUIET;
    end

    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      quiet_cnt_q <= '0;
      round_cnt_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      quiet_cnt_q <= quiet_cnt_d;
      round_cnt_q <= round_cnt_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    lfsr_shift_en = 1'b0;
    text_in_sel   = 1'b0;
    text_reg_en   = 1'b0;
    done          = 1'b0;
    busy          = (state_q != S_IDLE);
    unique case (state_q)
      S_ADVANCE: lfsr_shift_en = 1'b1;
      S_LOAD:    text_reg_en   = 1'b1;
      S_CHAIN: begin
        text_reg_en = 1'b1;
        text_in_sel = 1'b1;
      end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
    trigger     = text_reg_en;
    trace_count = count_q;
  end

endmodule

// File: tb/tb_sbox_trace_scheduler.sv
// Bench for sbox_trace_scheduler: phase-arithmetic trace model checked every cycle,
// plus directed literal timing checks for each scenario.
module tb_sbox_trace_scheduler;

  logic       ICE_CLK = 1'b0;
  logic       resetn, start, free_run, abort;
  logic [7:0] cfg_quiet;
  logic [3:0] cfg_rounds;

  logic        shift, sel, en, trig, busy, done;
  logic [15:0] count;
  logic        shift4, sel4, en4, trig4, busy4, done4;
  logic [3:0]  count4;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 ICE_CLK = ~ICE_CLK;

  sbox_trace_scheduler dut (
    .ICE_CLK(ICE_CLK), .resetn(resetn), .start(start), .free_run(free_run), .abort(abort),
    .cfg_quiet(cfg_quiet), .cfg_rounds(cfg_rounds),
    .lfsr_shift_en(shift), .text_in_sel(sel), .text_reg_en(en), .trigger(trig),
    .busy(busy), .done(done), .trace_count(count)
  );

  sbox_trace_scheduler #(.CNT_W(4)) dut4 (
    .ICE_CLK(ICE_CLK), .resetn(resetn), .start(start), .free_run(free_run), .abort(abort),
    .cfg_quiet(cfg_quiet), .cfg_rounds(cfg_rounds),
    .lfsr_shift_en(shift4), .text_in_sel(sel4), .text_reg_en(en4), .trigger(trig4),
    .busy(busy4), .done(done4), .trace_count(count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a trace is a phase number counted from the cycle that accepted it.
  // Phases 1..Q quiet, Q+1 shift, Q+2..Q+R+1 text_reg_en, Q+R+2 done.
  bit          m_active = 0;
  bit          m_valid = 0;
  int unsigned m_ph, m_q, m_r, m_count;

  always @(posedge ICE_CLK) begin
    if (!resetn) begin
      m_active = 0;
      m_count  = 0;
      m_valid  = 1;
    end else if (!m_active) begin
      if ((start || free_run) && !abort) begin
        m_active = 1; m_ph = 1; m_q = cfg_quiet;
        m_r = (cfg_rounds == 0) ? 1 : cfg_rounds;
      end
    end else if (abort) begin
      m_active = 0;
    end else if (m_ph == m_q + m_r + 2) begin
      m_count++;
      if (free_run) begin
        m_ph = 1; m_q = cfg_quiet;
        m_r = (cfg_rounds == 0) ? 1 : cfg_rounds;
      end else begin
        m_active = 0;
      end
    end else begin
      m_ph++;
    end
    #1;
    if (m_valid) begin : cmp
      bit e_shift, e_en, e_sel, e_done;
      e_shift = m_active && (m_ph == m_q + 1);
      e_en    = m_active && (m_ph >= m_q + 2) && (m_ph <= m_q + m_r + 1);
      e_sel   = e_en && (m_ph > m_q + 2);
      e_done  = m_active && (m_ph == m_q + m_r + 2);
      chk("m_shift", 32'(shift), 32'(e_shift));
      chk("m_en",    32'(en),    32'(e_en));
      chk("m_sel",   32'(sel),   32'(e_sel));
      chk("m_trig",  32'(trig),  32'(e_en));
      chk("m_busy",  32'(busy),  32'(m_active));
      chk("m_done",  32'(done),  32'(e_done));
      chk("m_count", 32'(count), m_count & 32'hFFFF);
      chk("m_count4", 32'(count4), m_count & 32'hF);
      chk("m_busy4", 32'(busy4), 32'(m_active));
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge ICE_CLK);
  endtask

  task automatic do_reset();
    @(negedge ICE_CLK);
    resetn = 0; start = 0; free_run = 0; abort = 0;
    cyc(2);
    resetn = 1;
  endtask

  initial begin
    resetn = 0; start = 0; free_run = 0; abort = 0; cfg_quiet = 0; cfg_rounds = 0;
    cyc(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {shift, sel, en, trig, done}, 0);
    chk("rst_count", 32'(count), 0);
    resetn = 1;
    cyc(1);

    // 1: Q=3 R=4 single shot; cfg changed after latch must not matter
    cfg_quiet = 3; cfg_rounds = 4; start = 1;
    cyc(1); start = 0; cfg_quiet = 50; cfg_rounds = 9;
    chk("c1_busy1", 32'(busy), 1);
    cyc(3); chk("c1_shift4", 32'(shift), 1);
    cyc(1); chk("c1_en5", {en, sel}, 2'b10);
    cyc(1); chk("c1_en6", {en, sel}, 2'b11);
    cyc(2); chk("c1_en8", {en, sel}, 2'b11);
    cyc(1); chk("c1_done9", {done, en, busy}, 3'b101);
    cyc(1); chk("c1_idle10", {busy, done}, 0); chk("c1_count", 32'(count), 1);

    // 2: R=0 treated as 1, Q=0
    do_reset();
    cfg_quiet = 0; cfg_rounds = 0; start = 1;
    cyc(1); start = 0; chk("c2_shift1", 32'(shift), 1);
    cyc(1); chk("c2_load2", {en, sel}, 2'b10);
    cyc(1); chk("c2_done3", {done, en}, 2'b10);
    cyc(1); chk("c2_idle4", 32'(busy), 0);

    // 3: free run Q=11 R=4, period 17
    do_reset();
    cfg_quiet = 11; cfg_rounds = 4; free_run = 1;
    cyc(12); chk("c3_shift12", 32'(shift), 1);
    cyc(5);  chk("c3_done17", 32'(done), 1);
    cyc(1);  chk("c3_rearm18", 32'(busy), 1);
    cyc(11); chk("c3_shift29", 32'(shift), 1);
    cyc(57); chk("c3_count5", 32'(count), 5); chk("c3_busy86", 32'(busy), 1);
    cyc(4);  free_run = 0;
    cyc(12); chk("c3_done102", 32'(done), 1);
    cyc(1);  chk("c3_idle103", 32'(busy), 0); chk("c3_count6", 32'(count), 6);

    // 4: abort in CHAIN, then start+abort together in IDLE
    do_reset();
    cfg_quiet = 2; cfg_rounds = 8; start = 1;
    cyc(1); start = 0;
    cyc(6); chk("c4_chain7", {en, sel}, 2'b11); abort = 1;
    cyc(1); abort = 0;
    chk("c4_idle8", {busy, en, shift, done}, 0); chk("c4_count", 32'(count), 0);
    start = 1; abort = 1;
    cyc(1); start = 0; abort = 0; chk("c4_stay", 32'(busy), 0);

    // 5: reset mid-QUIET after one completed trace, then case-1 timing again
    do_reset();
    cfg_quiet = 0; cfg_rounds = 1; start = 1;
    cyc(1); start = 0;
    cyc(3); chk("c5_pre_count", 32'(count), 1);
    cfg_quiet = 3; cfg_rounds = 4; start = 1;
    cyc(1); start = 0;
    cyc(1); resetn = 0;
    cyc(1); resetn = 1;
    chk("c5_outs", {busy, shift, en, sel, trig, done}, 0); chk("c5_count", 32'(count), 0);
    start = 1;
    cyc(1); start = 0;
    cyc(3); chk("c5_shift4", 32'(shift), 1);
    cyc(5); chk("c5_done9", 32'(done), 1);

    // 6: start held high; 17 traces of period 4 wrap the 4-bit counter
    do_reset();
    cfg_quiet = 0; cfg_rounds = 1; start = 1;
    cyc(60); chk("c6_cnt15", 32'(count4), 15);
    cyc(4);  chk("c6_cnt0",  32'(count4), 0);
    cyc(3);  start = 0;
    cyc(1);  chk("c6_cnt1",  32'(count4), 1); chk("c6_cnt17", 32'(count), 17);
    cyc(4);  chk("c6_noextra", 32'(count), 17); chk("c6_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
